pipelined_cla_adder: RTL
========================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor for operands of any multiple of the group size. The operand is split into GROUP-bit lookahead groups, and each group is computed in its own pipeline stage. The group carry-out is registered and passed to the next stage, which closes timing at wide WIDTH and sustains one operation per cycle. It sits between operand producers and result consumers on valid/ready streams and supports full backpressure.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of GROUP and ≥ GROUP, otherwise elaboration fails.
- GROUP, 4: bits per lookahead group and per pipeline stage.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  adder accepts the beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add) / borrow-in (sub).
- in_sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry-out; in sub mode 1 = no borrow.
- out_ovf  out  1  two's-complement overflow.

## Operation
- NG = WIDTH/GROUP stages, numbered 0..NG-1. Stage k computes bits [k*GROUP +: GROUP].
- Effective operands:
  - add: b' = in_b, c0 = in_cin.
  - sub: b' = ~in_b, c0 = ~in_cin, so the result is a − b − in_cin.
  - Inversion is applied at acceptance.
- Each group computes g = a&b', p = a^b' and full lookahead carries within the group, with no ripple inside the group. It outputs the group sum and group carry-out.
- Stage k registers:
  - a valid bit;
  - the finished sum bits for groups 0..k;
  - the unprocessed a/b' slices for groups k+1..NG-1;
  - the carry into group k+1.
- Final stage also registers:
  - cout = carry out of bit WIDTH−1;
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Stall rule: advance = !out_valid || out_ready. All stages shift together only when advance=1. in_ready = advance.
- A beat is accepted when in_valid && in_ready. When a stage shifts in nothing, it loads valid=0 (bubble).
- Bubbles are not collapsed, and ordering is strictly FIFO.
- While advance=0, every register holds. out_sum, out_cout and out_ovf stay stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync-to-clk release):
  - all valid bits 0, all data registers 0;
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0;
  - in_ready=1 combinationally after reset, because out_valid=0.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NG−1, i.e. NG cycles from acceptance to output, when there is no stall. With WIDTH=16, GROUP=4 the latency is 4 cycles.
- Throughput: 1 beat/cycle while out_ready=1.
- Each cycle of out_ready=0 while out_valid=1 adds exactly one cycle to every in-flight beat.
- in_ready depends combinationally on out_ready. There is no other input→output combinational path.
- Simultaneous output-consume and input-accept in the same cycle is legal, and the pipeline keeps full occupancy.
- Reset mid-operation discards all in-flight beats. No result from before reset ever appears.
- in_sub and in_cin are sampled only at acceptance, so mixed add/sub streams are legal per beat.

## Structure
- Package cla_pkg holds:
  - default GROUP constant;
  - function ng(WIDTH, GROUP);
  - a width/parameter legality check used by the elaboration assertion.
- Sub-module cla_group (combinational, GROUP-bit lookahead):
  - inputs: a, b, cin;
  - outputs: s, cout, group P/G, and carry into the group MSB (for ovf).
  - Instantiated NG times, once per stage.
- Top: the stage register array generated over k, plus the handshake logic.

## Test plan
- Add carry through all groups: WIDTH=16, a=0xFFFF, b=0x0001, cin=0, add → after 4 cycles sum=0x0000, cout=1, ovf=0.
- Signed overflow:
  - a=0x7FFF + b=0x0001 → sum=0x8000, cout=0, ovf=1.
  - sub a=0x8000 − b=0x0001, cin=0 → sum=0x7FFF, cout=1, ovf=1.
- Borrow-in: sub a=0x0000, b=0x0000, cin=1 → sum=0xFFFF, cout=0, ovf=0.
- Backpressure:
  - Fill the pipe with 4 beats, then hold out_ready=0 for 3 cycles → in_ready=0 and out_sum/out_cout/out_ovf held stable.
  - Release → 4 results in order, none lost or duplicated.
- Reset mid-stream: 3 beats in flight, pulse rst_n low asynchronously between edges → out_valid=0 immediately. No out_valid for NG cycles after release with in_valid=0.
- Random stream: 1000 beats with random in_valid, out_ready, in_sub, in_cin, at WIDTH=16/GROUP=4 and WIDTH=32/GROUP=8 → every result matches the golden model {cout,sum} = a ± b ± cin, with ovf matching, in order.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and parameter helpers for the pipelined lookahead adder
package cla_pkg;
    localparam int GROUP_DEF = 4;

    function automatic int ng(input int width, input int group);
        return width / group;
    endfunction

    function automatic bit param_ok(input int width, input int group);
        return group > 0 && width >= group && width % group == 0;
    endfunction
endpackage

// File: rtl/pipelined_cla_adder_if.sv
// pipelined_cla_adder_if: operand and result valid/ready streams of the adder
interface pipelined_cla_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/cla_group.sv
// cla_group: one lookahead group, every carry a flat sum of products of bit g/p
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = GROUP_DEF
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout,
    output logic             p_grp,
    output logic             g_grp,
    output logic             c_msb
);
    logic [GROUP-1:0] p, g;
    logic [GROUP:0]   c, gen, prop;

    assign p = a ^ b;
    assign g = a & b;

    // gen[i]: carry into bit i generated inside the group; prop[i]: cin reaches bit i
    always_comb begin
        logic t;
        gen  = '0;
        prop = '0;
        t    = 1'b0;
        for (int i = 0; i <= GROUP; i++) begin
            prop[i] = 1'b1;
            for (int j = 0; j < i; j++) prop[i] = prop[i] & p[j];
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int m = j + 1; m < i; m++) t = t & p[m];
                gen[i] = gen[i] | t;
            end
        end
    end

    assign c     = gen | (prop & {(GROUP+1){cin}});
    assign s     = p ^ c[GROUP-1:0];
    assign cout  = c[GROUP];
    assign c_msb = c[GROUP-1];
    assign p_grp = prop[GROUP];
    assign g_grp = gen[GROUP];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: add/subtract one lookahead group per stage with a registered group carry
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = GROUP_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int NG = ng(WIDTH, GROUP);

    if (!param_ok(WIDTH, GROUP)) begin : bad_params
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
    end

    logic             adv, take, c0;
    logic [WIDTH-1:0] b0;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign take         = bus.in_valid && adv;
    assign b0           = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign c0           = bus.in_cin ^ bus.in_sub;

    for (genvar k = 0; k < NG; k++) begin : st
        localparam int L = WIDTH - k*GROUP;
        logic [L-1:0]           pa, pb;
        logic                   ci, vi, gc, gm, gp, gg;
        logic [GROUP-1:0]       gs;
        logic [(k+1)*GROUP-1:0] sn;
        if (k == 0) begin : src
            assign pa = bus.in_a;
            assign pb = b0;
            assign ci = c0;
            assign vi = take;
            assign sn = gs;
        end else begin : src
            assign pa = rg[k-1].a;
            assign pb = rg[k-1].b;
            assign ci = rg[k-1].c;
            assign vi = rg[k-1].v;
            assign sn = {gs, rg[k-1].s};
        end
        cla_group #(.GROUP(GROUP)) u_grp (
            .a(pa[GROUP-1:0]), .b(pb[GROUP-1:0]), .cin(ci),
            .s(gs), .cout(gc), .p_grp(gp), .g_grp(gg), .c_msb(gm)
        );
        // group carry must agree with both the group P/G form and the MSB carry
        always_comb assert (gc == (gg | (gp & ci)) &&
                            gc == ((pa[GROUP-1] & pb[GROUP-1]) | ((pa[GROUP-1] ^ pb[GROUP-1]) & gm)));
    end

    for (genvar k = 0; k < NG-1; k++) begin : rg
        localparam int L = WIDTH - (k+1)*GROUP;
        logic                   v, c;
        logic [(k+1)*GROUP-1:0] s;
        logic [L-1:0]           a, b;
        // stage k: finished low sum, pending high operands and carry, shifted as one
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                v <= 1'b0;
                c <= 1'b0;
                s <= '0;
                a <= '0;
                b <= '0;
            end else if (adv) begin
                v <= st[k].vi;
                c <= st[k].gc;
                s <= st[k].sn;
                a <= st[k].pa[WIDTH-k*GROUP-1:GROUP];
                b <= st[k].pb[WIDTH-k*GROUP-1:GROUP];
            end
    end

    // last stage: full result plus carry-out and overflow from the top group
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_cout  <= 1'b0;
            bus.out_ovf   <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= st[NG-1].vi;
            bus.out_sum   <= st[NG-1].sn;
            bus.out_cout  <= st[NG-1].gc;
            bus.out_ovf   <= st[NG-1].gc ^ st[NG-1].gm;
        end
endmodule
